// File: rtl/decode_pkg.sv
// Shared opcodes, format codes and the decoded-record bundle
// used by the decode stage and its combinational decoder.
package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_32       = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I decoder: raw instruction word in,
// decoded record and sign-extended immediate out.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic [31:0]     instr,
    output dec_t            rec,
    output logic [XLEN-1:0] imm
);

    localparam bit RV64 = (XLEN == 64) && RV64_OPS;

    logic [6:0]  opc;
    logic        is_u, is_j, is_i, is_s, is_b, is_r;
    logic [31:0] imm32;
    fmt_e        fmt;

    assign opc = instr[6:0];

    // full 7-bit compare also rejects instr[1:0] != 2'b11
    assign is_u = (opc == OP_LUI) || (opc == OP_AUIPC);
    assign is_j = (opc == OP_JAL);
    assign is_i = (opc == OP_JALR) || (opc == OP_LOAD) ||
                  (opc == OP_IMM) || (opc == OP_MISC_MEM) ||
                  (opc == OP_SYSTEM) ||
                  (RV64 && (opc == OP_IMM_32));
    assign is_s = (opc == OP_STORE);
    assign is_b = (opc == OP_BRANCH);
    assign is_r = (opc == OP_OP) || (RV64 && (opc == OP_32));

    always_comb begin
        fmt   = FMT_NONE;
        imm32 = '0;
        unique case (1'b1)
            is_u: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            is_j: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            end
            is_i: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            is_s: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            is_b: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            is_r: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
            default: begin
                fmt   = FMT_NONE;
                imm32 = '0;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    always_comb begin
        rec         = '0;
        rec.opcode  = instr[6:0];
        rec.rd      = instr[11:7];
        rec.rs1     = instr[19:15];
        rec.rs2     = instr[24:20];
        rec.funct3  = instr[14:12];
        rec.funct7  = instr[31:25];
        rec.fmt     = fmt;
        rec.illegal = (instr[1:0] != 2'b11) || (fmt == FMT_NONE);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input side and buffers
// up to two records behind a valid/ready handshake.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output fmt_e            out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end

    dec_t            rec_d;
    logic [XLEN-1:0] imm_d;

    decode_comb #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_dec (
        .instr (in_instr),
        .rec   (rec_d),
        .imm   (imm_d)
    );

    dec_t            rec_q [2];
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] pc_q  [2];
    logic [1:0]      cnt;
    logic [1:0]      cnt_nx;
    logic            head;
    logic            wr;
    logic            rdy_q;
    logic            push;
    logic            pop;

    assign push = in_valid && rdy_q && !flush;
    assign pop  = (cnt != 2'd0) && out_ready;
    assign wr   = head ^ cnt[0];

    always_comb begin
        cnt_nx = cnt;
        if (flush) begin
            cnt_nx = 2'd0;
        end else begin
            cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            head  <= 1'b0;
            rdy_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                rec_q[i] <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            cnt   <= cnt_nx;
            rdy_q <= (cnt_nx < 2'd2);
            if (pop) begin
                head <= ~head;
            end
            if (push) begin
                rec_q[wr] <= rec_d;
                imm_q[wr] <= imm_d;
                pc_q[wr]  <= in_pc;
            end
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (cnt != 2'd0);
    assign out_pc      = pc_q[head];
    assign out_imm     = imm_q[head];
    assign out_opcode  = rec_q[head].opcode;
    assign out_rd      = rec_q[head].rd;
    assign out_rs1     = rec_q[head].rs1;
    assign out_rs2     = rec_q[head].rs2;
    assign out_funct3  = rec_q[head].funct3;
    assign out_funct7  = rec_q[head].funct7;
    assign out_fmt     = rec_q[head].fmt;
    assign out_illegal = rec_q[head].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: one XLEN=32 and one XLEN=64
// instance, expected records queued on accept, checked on delivery.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;

    logic        iv32, ir32, ov32, or32, oill32;
    logic [31:0] ii32, ipc32, opc32, oimm32;
    logic [6:0]  oop32, of7_32;
    logic [4:0]  ord32, ors1_32, ors2_32;
    logic [2:0]  of3_32, ofmt32;

    logic        iv64, ir64, ov64, or64, oill64;
    logic [31:0] ii64;
    logic [63:0] ipc64, opc64, oimm64;
    logic [6:0]  oop64, of7_64;
    logic [4:0]  ord64, ors1_64, ors2_64;
    logic [2:0]  of3_64, ofmt64;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv32), .in_ready(ir32),
        .in_instr(ii32), .in_pc(ipc32),
        .out_valid(ov32), .out_ready(or32), .out_pc(opc32),
        .out_opcode(oop32), .out_rd(ord32), .out_rs1(ors1_32),
        .out_rs2(ors2_32), .out_funct3(of3_32), .out_funct7(of7_32),
        .out_fmt(ofmt32), .out_imm(oimm32), .out_illegal(oill32)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv64), .in_ready(ir64),
        .in_instr(ii64), .in_pc(ipc64),
        .out_valid(ov64), .out_ready(or64), .out_pc(opc64),
        .out_opcode(oop64), .out_rd(ord64), .out_rs1(ors1_64),
        .out_rs2(ors2_64), .out_funct3(of3_64), .out_funct7(of7_64),
        .out_fmt(ofmt64), .out_imm(oimm64), .out_illegal(oill64)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int tests = 0;
    int fails = 0;
    logic [31:0] snap_pc, snap_imm;

    function automatic exp_t model(logic [31:0] i, logic [63:0] pc,
                                   bit w64);
        exp_t e;
        logic signed [63:0] s;
        s     = '0;
        e     = '0;
        e.pc  = pc;
        e.op  = i[6:0];
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3  = i[14:12];
        e.f7  = i[31:25];
        e.ill = 1'b0;
        case (i[6:0])
            7'h37, 7'h17: begin
                e.fmt = 3'd5;
                s = $signed({i[31:12], 12'b0});
            end
            7'h6f: begin
                e.fmt = 3'd6;
                s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            end
            7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: begin
                e.fmt = 3'd2;
                s = $signed(i[31:20]);
            end
            7'h1b: begin
                if (w64) begin
                    e.fmt = 3'd2;
                    s = $signed(i[31:20]);
                end else begin
                    e.fmt = 3'd0;
                    e.ill = 1'b1;
                end
            end
            7'h23: begin
                e.fmt = 3'd3;
                s = $signed({i[31:25], i[11:7]});
            end
            7'h63: begin
                e.fmt = 3'd4;
                s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            end
            7'h33: e.fmt = 3'd1;
            7'h3b: begin
                e.fmt = w64 ? 3'd1 : 3'd0;
                e.ill = !w64;
            end
            default: begin
                e.fmt = 3'd0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = w64 ? s : {32'b0, s[31:0]};
        return e;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n && ov32) begin
            tests++;
            if (q32.size() == 0) begin
                fails++;
                $display("FAIL sb32_unexpected pc=%h", opc32);
            end else begin
                e32 = q32[0];
                if ({32'b0, opc32} !== e32.pc || oop32 !== e32.op ||
                    ord32 !== e32.rd || ors1_32 !== e32.rs1 ||
                    ors2_32 !== e32.rs2 || of3_32 !== e32.f3 ||
                    of7_32 !== e32.f7 || ofmt32 !== e32.fmt ||
                    {32'b0, oimm32} !== e32.imm || oill32 !== e32.ill) begin
                    fails++;
                    $display("FAIL sb32 pc=%h fmt=%0d imm=%h ill=%b rd=%0d exp pc=%h fmt=%0d imm=%h ill=%b rd=%0d",
                             opc32, ofmt32, oimm32, oill32, ord32,
                             e32.pc, e32.fmt, e32.imm, e32.ill, e32.rd);
                end
                if (or32) void'(q32.pop_front());
            end
        end
        if (rst_n && ov64) begin
            tests++;
            if (q64.size() == 0) begin
                fails++;
                $display("FAIL sb64_unexpected pc=%h", opc64);
            end else begin
                e64 = q64[0];
                if (opc64 !== e64.pc || oop64 !== e64.op ||
                    ord64 !== e64.rd || ors1_64 !== e64.rs1 ||
                    ors2_64 !== e64.rs2 || of3_64 !== e64.f3 ||
                    of7_64 !== e64.f7 || ofmt64 !== e64.fmt ||
                    oimm64 !== e64.imm || oill64 !== e64.ill) begin
                    fails++;
                    $display("FAIL sb64 pc=%h fmt=%0d imm=%h ill=%b rd=%0d exp pc=%h fmt=%0d imm=%h ill=%b rd=%0d",
                             opc64, ofmt64, oimm64, oill64, ord64,
                             e64.pc, e64.fmt, e64.imm, e64.ill, e64.rd);
                end
                if (or64) void'(q64.pop_front());
            end
        end
        if (flush) begin
            q32.delete();
            q64.delete();
        end
    end

    task automatic drv32(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic rdy,
                         input logic fl);
        @(negedge clk);
        #1;
        iv32 = v; ii32 = ins; ipc32 = pc; or32 = rdy; flush = fl;
        if (v && ir32 && !fl) q32.push_back(model(ins, {32'b0, pc}, 1'b0));
    endtask

    task automatic drv64(input logic v, input logic [31:0] ins,
                         input logic [63:0] pc, input logic rdy,
                         input logic fl);
        @(negedge clk);
        #1;
        iv64 = v; ii64 = ins; ipc64 = pc; or64 = rdy; flush = fl;
        if (v && ir64 && !fl) q64.push_back(model(ins, pc, 1'b1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || ov64 !== 1'b0 || ir64 !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs ov32=%b ir32=%b ov64=%b ir64=%b want 0 1 0 1",
                     ov32, ir32, ov64, ir64);
        end
        tests++;
        if (opc32 !== 32'd0 || oimm32 !== 32'd0 || ofmt32 !== 3'd0 ||
            oill32 !== 1'b0 || ord32 !== 5'd0 || oop32 !== 7'd0) begin
            fails++;
            $display("FAIL reset_data32 pc=%h imm=%h fmt=%0d ill=%b want zeros",
                     opc32, oimm32, ofmt32, oill32);
        end
        tests++;
        if (opc64 !== 64'd0 || oimm64 !== 64'd0 || ofmt64 !== 3'd0) begin
            fails++;
            $display("FAIL reset_data64 pc=%h imm=%h fmt=%0d want zeros",
                     opc64, oimm64, ofmt64);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drv32(1, 32'hFFF00093, 32'h100, 1, 0);
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b1 || ord32 !== 5'd1 || ors1_32 !== 5'd0 ||
            ofmt32 !== 3'd2 || oimm32 !== 32'hFFFFFFFF || oill32 !== 1'b0) begin
            fails++;
            $display("FAIL addi ov=%b rd=%0d rs1=%0d fmt=%0d imm=%h ill=%b want 1 1 0 2 ffffffff 0",
                     ov32, ord32, ors1_32, ofmt32, oimm32, oill32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b0) begin
            fails++;
            $display("FAIL addi_drain ov=%b want 0", ov32);
        end
    endtask

    task automatic test_back_to_back();
        drv32(1, 32'h00112623, 32'h200, 1, 0);
        drv32(1, 32'hFE000EE3, 32'h204, 1, 0);
        #1;
        tests++;
        if (ir32 !== 1'b1 || ov32 !== 1'b1 || opc32 !== 32'h200 ||
            ofmt32 !== 3'd3 || oimm32 !== 32'd12 || ors1_32 !== 5'd2 ||
            ors2_32 !== 5'd1) begin
            fails++;
            $display("FAIL b2b_sw ir=%b pc=%h fmt=%0d imm=%h rs1=%0d rs2=%0d want 1 200 3 c 2 1",
                     ir32, opc32, ofmt32, oimm32, ors1_32, ors2_32);
        end
        drv32(1, 32'h001000EF, 32'h208, 1, 0);
        #1;
        tests++;
        if (ir32 !== 1'b1 || opc32 !== 32'h204 || ofmt32 !== 3'd4 ||
            oimm32 !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL b2b_beq ir=%b pc=%h fmt=%0d imm=%h want 1 204 4 fffffffc",
                     ir32, opc32, ofmt32, oimm32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ir32 !== 1'b1 || opc32 !== 32'h208 || ofmt32 !== 3'd6 ||
            oimm32 !== 32'h800 || ord32 !== 5'd1) begin
            fails++;
            $display("FAIL b2b_jal ir=%b pc=%h fmt=%0d imm=%h rd=%0d want 1 208 6 800 1",
                     ir32, opc32, ofmt32, oimm32, ord32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain ov=%b want 0", ov32);
        end
    endtask

    task automatic test_backpressure();
        drv32(1, 32'h00500113, 32'h300, 0, 0);
        drv32(1, 32'h00A18193, 32'h304, 0, 0);
        #1;
        tests++;
        if (ov32 !== 1'b1 || ir32 !== 1'b1 || opc32 !== 32'h300) begin
            fails++;
            $display("FAIL bp_first ov=%b ir=%b pc=%h want 1 1 300",
                     ov32, ir32, opc32);
        end
        drv32(1, 32'h123452B7, 32'h308, 0, 0);
        #1;
        snap_pc  = opc32;
        snap_imm = oimm32;
        tests++;
        if (ir32 !== 1'b0 || opc32 !== 32'h300) begin
            fails++;
            $display("FAIL bp_full ir=%b pc=%h want 0 300", ir32, opc32);
        end
        for (int k = 0; k < 3; k++) begin
            drv32(1, 32'h123452B7, 32'h308, 0, 0);
            #1;
            tests++;
            if (ir32 !== 1'b0 || ov32 !== 1'b1 || opc32 !== snap_pc ||
                oimm32 !== snap_imm) begin
                fails++;
                $display("FAIL bp_stable ir=%b ov=%b pc=%h imm=%h want 0 1 %h %h",
                         ir32, ov32, opc32, oimm32, snap_pc, snap_imm);
            end
        end
        drv32(1, 32'h123452B7, 32'h308, 1, 0);
        drv32(1, 32'h123452B7, 32'h308, 1, 0);
        #1;
        tests++;
        if (opc32 !== 32'h304) begin
            fails++;
            $display("FAIL bp_order2 pc=%h want 304", opc32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (opc32 !== 32'h308 || ofmt32 !== 3'd5 || oimm32 !== 32'h12345000) begin
            fails++;
            $display("FAIL bp_order3 pc=%h fmt=%0d imm=%h want 308 5 12345000",
                     opc32, ofmt32, oimm32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b0 || q32.size() != 0) begin
            fails++;
            $display("FAIL bp_drain ov=%b pending=%0d want 0 0", ov32, q32.size());
        end
    endtask

    task automatic test_flush();
        drv32(1, 32'h00000033, 32'h400, 0, 0);
        drv32(1, 32'h40208033, 32'h404, 0, 0);
        drv32(1, 32'h00100093, 32'h408, 0, 1);
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            fails++;
            $display("FAIL flush_full ov=%b ir=%b want 0 1", ov32, ir32);
        end
        for (int k = 0; k < 3; k++) begin
            drv32(0, 0, 0, 1, 0);
            #1;
            tests++;
            if (ov32 !== 1'b0) begin
                fails++;
                $display("FAIL flush_ghost ov=%b pc=%h want 0", ov32, opc32);
            end
        end
        drv32(1, 32'h00C00513, 32'h500, 0, 0);
        drv32(1, 32'h00D00593, 32'h504, 1, 1);
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            fails++;
            $display("FAIL flush_occ1 ov=%b ir=%b want 0 1", ov32, ir32);
        end
    endtask

    task automatic test_illegal();
        drv32(1, 32'h00000000, 32'h600, 1, 0);
        drv32(1, 32'h0000001B, 32'h604, 1, 0);
        #1;
        tests++;
        if (oill32 !== 1'b1 || ofmt32 !== 3'd0 || oimm32 !== 32'd0 ||
            opc32 !== 32'h600) begin
            fails++;
            $display("FAIL ill_zero ill=%b fmt=%0d imm=%h pc=%h want 1 0 0 600",
                     oill32, ofmt32, oimm32, opc32);
        end
        drv32(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (oill32 !== 1'b1 || ofmt32 !== 3'd0 || oimm32 !== 32'd0 ||
            opc32 !== 32'h604) begin
            fails++;
            $display("FAIL ill_op32 ill=%b fmt=%0d imm=%h pc=%h want 1 0 0 604",
                     oill32, ofmt32, oimm32, opc32);
        end
        drv32(0, 0, 0, 1, 0);
        drv64(1, 32'h0000001B, 64'h700, 1, 0);
        drv64(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (oill64 !== 1'b0 || ofmt64 !== 3'd2 || ov64 !== 1'b1) begin
            fails++;
            $display("FAIL rv64_opimm32 ill=%b fmt=%0d ov=%b want 0 2 1",
                     oill64, ofmt64, ov64);
        end
    endtask

    task automatic test_rv64();
        drv64(1, 32'h800002B7, 64'h1_0000_0000, 1, 0);
        drv64(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (oimm64 !== 64'hFFFFFFFF80000000 || ord64 !== 5'd5 ||
            ofmt64 !== 3'd5 || opc64 !== 64'h1_0000_0000) begin
            fails++;
            $display("FAIL rv64_lui imm=%h rd=%0d fmt=%0d pc=%h want ffffffff80000000 5 5 100000000",
                     oimm64, ord64, ofmt64, opc64);
        end
        drv64(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        drv64(1, 32'hFE010113, 64'h800, 0, 0);
        drv64(1, 32'h00812623, 64'h804, 0, 0);
        drv64(1, 32'h0000003B, 64'h808, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ov64 !== 1'b0 || ir64 !== 1'b1 || opc64 !== 64'd0 || ofmt64 !== 3'd0) begin
            fails++;
            $display("FAIL reset_async ov=%b ir=%b pc=%h fmt=%0d want 0 1 0 0",
                     ov64, ir64, opc64, ofmt64);
        end
        q32.delete();
        q64.delete();
        iv64 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drv64(1, 32'h0000003B, 64'h900, 1, 0);
        drv64(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (ov64 !== 1'b1 || ofmt64 !== 3'd1 || oill64 !== 1'b0) begin
            fails++;
            $display("FAIL reset_resume ov=%b fmt=%0d ill=%b want 1 1 0",
                     ov64, ofmt64, oill64);
        end
        drv64(0, 0, 0, 1, 0);
        drv64(0, 0, 0, 1, 0);
        #1;
        tests++;
        if (q64.size() != 0 || q32.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover q32=%0d q64=%0d want 0 0",
                     q32.size(), q64.size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        iv32 = 1'b0; ii32 = '0; ipc32 = '0; or32 = 1'b1;
        iv64 = 1'b0; ii64 = '0; ipc64 = '0; or64 = 1'b1;
        #1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_rv64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction-decode pipeline stage between fetch and execute.
- Extracts register and function fields, classifies the instruction format, builds a single XLEN-wide sign-extended immediate and flags illegal encodings.
- Buffers up to two decoded instructions behind a valid/ready handshake, so fetch sees full throughput under backpressure.
- Supports pipeline flush.

Parameters:
- XLEN, 32, datapath/immediate/PC width; legal values 32 or 64; any other value is an elaboration error.
- RV64_OPS, (XLEN==64), when 1, OP-IMM-32 (0011011) and OP-32 (0111011) are legal opcodes; forced to 0 when XLEN==32.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all buffered entries and any same-cycle input
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered, depends only on occupancy
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  PC of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  execute accepts head entry
- out_pc  output  XLEN  PC of head entry
- out_opcode  output  7  instr[6:0]
- out_rd  output  5  instr[11:7]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_fmt  output  3  format code (package enum)
- out_imm  output  XLEN  immediate, sign-extended to XLEN
- out_illegal  output  1  head entry is an illegal encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - occupancy = 0, head pointer = 0.
  - out_valid = 0, in_ready = 1.
  - All out_* data fields = 0, including out_fmt = FMT_NONE.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid=1 after edge N (1-cycle latency) if the buffer was empty.
- Buffer:
  - Two-entry FIFO of decoded records; decoding is done combinationally on the input side, then the record is stored.
  - in_ready = (occupancy < 2).
  - Simultaneous push and pop at occupancy 1: occupancy stays 1, order is preserved.
  - Push at occupancy 2 cannot occur, because in_ready=0.
  - Pop at occupancy 0 is ignored.
  - The head pointer wraps modulo 2.
- out_* data is held stable while out_valid && !out_ready; data changes only after a pop.
- Format select by opcode[6:2]:
  - LUI, AUIPC → U.
  - JAL → J.
  - JALR, LOAD, OP-IMM, OP-IMM-32, MISC-MEM, SYSTEM → I.
  - STORE → S.
  - BRANCH → B.
  - OP, OP-32 → R (imm = 0).
  - Anything else → FMT_NONE (imm = 0).
- Immediates (sign bit is instr[31], extended to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, then sign-extended above bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal detection: illegal = (instr[1:0] != 2'b11) or opcode not in the legal set. The legal set includes the -32 opcodes only when RV64_OPS=1.
- Illegal instructions are passed downstream (not dropped) with fmt = FMT_NONE.
- Field decoding of funct3/funct7 is out of scope.
- Flush:
  - Synchronous: at the edge where flush=1, occupancy becomes 0 and out_valid becomes 0.
  - Any same-cycle input is not stored, even if in_valid && in_ready.
  - A same-cycle output transfer still counts as delivered.
  - in_ready = 1 on the next cycle.
- Reset mid-operation: buffered entries are lost immediately (asynchronous); outputs return to reset values.

Decomposition:
- Package decode_pkg holds:
  - Opcode localparams: OP_LUI=0110111, OP_AUIPC=0010111, OP_JAL=1101111, OP_JALR=1100111, OP_BRANCH=1100011, OP_LOAD=0000011, OP_STORE=0100011, OP_IMM=0010011, OP_OP=0110011, OP_MISC_MEM=0001111, OP_SYSTEM=1110011, OP_IMM_32, OP_32.
  - Format enum FMT_NONE=0, R=1, I=2, S=3, B=4, U=5, J=6.
  - Decoded-record struct.
- One sub-module: decode_comb (purely combinational, instr → record, parametrised by XLEN and RV64_OPS).
- decode_stage holds the FIFO, pointers and handshake.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi x1,x0,-1), XLEN=32, out_ready=1 → next cycle: out_valid=1, rd=1, rs1=0, fmt=I, imm=0xFFFFFFFF, illegal=0.
- Stream without stall: 0x00112623 (sw x1,12(x2)), then 0xFE000EE3 (beq x0,x0,-4), then 0x001000EF (jal x1,2048), one per cycle:
  - Outputs appear in order on consecutive cycles.
  - sw: S, imm=12, rs1=2, rs2=1.
  - beq: B, imm=0xFFFFFFFC.
  - jal: J, imm=0x800, rd=1.
  - in_ready stays 1 throughout.
- Backpressure: out_ready=0, offer 3 instructions:
  - Two are accepted; in_ready=0 from the cycle after the 2nd accept.
  - The third is held until out_ready=1.
  - All three drain in order.
  - out_* is stable during the stall.
- Flush with occupancy 2 and in_valid=1 in the same cycle → next cycle out_valid=0 and in_ready=1; the flushed and same-cycle instructions never appear at the output.
- Illegal: 0x00000000 and 0x0000001B with XLEN=32 → illegal=1, fmt=FMT_NONE, imm=0. With XLEN=64, 0x0000001B → illegal=0, fmt=I.
- XLEN=64: 0x800002B7 (lui x5,0x80000) → imm=0xFFFFFFFF80000000, rd=5, fmt=U. Also assert rst_n low mid-stream → out_valid=0 immediately, without waiting for a clock edge.
